// File: rtl/jtag_tap_ctrl_if.sv
// rtl/jtag_tap_ctrl_if.sv - JTAG pins and USER data register bundle for jtag_tap_ctrl
interface jtag_tap_ctrl_if #(
    parameter int IR_WIDTH      = 4,
    parameter int USER_DR_WIDTH = 16
);
    logic                     tms;
    logic                     tdi;
    logic                     tdo;
    logic                     tdo_en;
    logic [3:0]               tap_state;
    logic [IR_WIDTH-1:0]      ir_out;
    logic [USER_DR_WIDTH-1:0] user_dr_in;
    logic [USER_DR_WIDTH-1:0] user_dr_out;
    logic                     user_update;

    modport master (
        output tms, tdi, user_dr_in,
        input  tdo, tdo_en, tap_state, ir_out, user_dr_out, user_update
    );

    modport slave (
        input  tms, tdi, user_dr_in,
        output tdo, tdo_en, tap_state, ir_out, user_dr_out, user_update
    );
endinterface

// File: rtl/jtag_tap_ctrl.sv
// rtl/jtag_tap_ctrl.sv - IEEE 1149.1 TAP controller with IDCODE/BYPASS and optional USER DR
// Optional feature macro: JTAG_TAP_USER_DR_EN (USER register, opcode 8)
module jtag_tap_ctrl #(
    parameter int          IR_WIDTH      = 4,
    parameter logic [31:0] IDCODE_VAL    = 32'h1234_5679,
    parameter int          USER_DR_WIDTH = 16
) (
    input  logic           tck,
    input  logic           trst,
    jtag_tap_ctrl_if.slave tap
);

    typedef enum logic [3:0] {
        TLR    = 4'hF,
        RTI    = 4'hC,
        SEL_DR = 4'h7,
        CAP_DR = 4'h6,
        SH_DR  = 4'h2,
        EX1_DR = 4'h1,
        PA_DR  = 4'h3,
        EX2_DR = 4'h0,
        UPD_DR = 4'h5,
        SEL_IR = 4'h4,
        CAP_IR = 4'hE,
        SH_IR  = 4'hA,
        EX1_IR = 4'h9,
        PA_IR  = 4'hB,
        EX2_IR = 4'h8,
        UPD_IR = 4'hD
    } tap_state_e;

    localparam logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(1);

    tap_state_e          state;
    tap_state_e          state_nxt;
    logic [IR_WIDTH-1:0] ir_sr;
    logic [IR_WIDTH-1:0] ir_q;
    logic [31:0]         id_sr;
    logic                bypass_sr;
    logic                sel_idcode;
    logic                sel_user;
    logic                sel_bypass;
    logic                dr_lsb;
    logic                tdo_q;
    logic                tdo_en_q;

    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            state <= TLR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            TLR:    state_nxt = tap.tms ? TLR    : RTI;
            RTI:    state_nxt = tap.tms ? SEL_DR : RTI;
            SEL_DR: state_nxt = tap.tms ? SEL_IR : CAP_DR;
            CAP_DR: state_nxt = tap.tms ? EX1_DR : SH_DR;
            SH_DR:  state_nxt = tap.tms ? EX1_DR : SH_DR;
            EX1_DR: state_nxt = tap.tms ? UPD_DR : PA_DR;
            PA_DR:  state_nxt = tap.tms ? EX2_DR : PA_DR;
            EX2_DR: state_nxt = tap.tms ? UPD_DR : SH_DR;
            UPD_DR: state_nxt = tap.tms ? SEL_DR : RTI;
            SEL_IR: state_nxt = tap.tms ? TLR    : CAP_IR;
            CAP_IR: state_nxt = tap.tms ? EX1_IR : SH_IR;
            SH_IR:  state_nxt = tap.tms ? EX1_IR : SH_IR;
            EX1_IR: state_nxt = tap.tms ? UPD_IR : PA_IR;
            PA_IR:  state_nxt = tap.tms ? EX2_IR : PA_IR;
            EX2_IR: state_nxt = tap.tms ? UPD_IR : SH_IR;
            UPD_IR: state_nxt = tap.tms ? SEL_DR : RTI;
            default: state_nxt = TLR;
        endcase
    end

    assign sel_idcode = (ir_q == OP_IDCODE);
    assign sel_bypass = !sel_idcode && !sel_user;

    // Instruction path plus the IDCODE and BYPASS data registers.
    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            ir_sr     <= '0;
            ir_q      <= OP_IDCODE;
            id_sr     <= '0;
            bypass_sr <= 1'b0;
        end else begin
            case (state)
                CAP_IR: ir_sr <= IR_WIDTH'(1);
                SH_IR:  ir_sr <= {tap.tdi, ir_sr[IR_WIDTH-1:1]};
                CAP_DR: begin
                    if (sel_idcode) id_sr     <= IDCODE_VAL;
                    if (sel_bypass) bypass_sr <= 1'b0;
                end
                SH_DR: begin
                    if (sel_idcode) id_sr     <= {tap.tdi, id_sr[31:1]};
                    if (sel_bypass) bypass_sr <= tap.tdi;
                end
                default: ;
            endcase
            // Keyed on the next state so ir_out already reads IDCODE on arrival in TLR,
            // even when the exit path to TLR went through UPD_IR.
            if (state_nxt == TLR) begin
                ir_q <= OP_IDCODE;
            end else if (state == UPD_IR) begin
                ir_q <= ir_sr;
            end
        end
    end

`ifdef JTAG_TAP_USER_DR_EN
    localparam logic [IR_WIDTH-1:0] OP_USER = IR_WIDTH'(8);

    logic [USER_DR_WIDTH-1:0] user_sr;
    logic [USER_DR_WIDTH-1:0] user_q;
    logic                     user_upd_q;

    assign sel_user = (ir_q == OP_USER);

    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            user_sr    <= '0;
            user_q     <= '0;
            user_upd_q <= 1'b0;
        end else begin
            user_upd_q <= 1'b0;
            if (sel_user) begin
                case (state)
                    CAP_DR: user_sr <= tap.user_dr_in;
                    SH_DR:  user_sr <= {tap.tdi, user_sr[USER_DR_WIDTH-1:1]};
                    UPD_DR: begin
                        user_q     <= user_sr;
                        user_upd_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        dr_lsb = bypass_sr;
        if (sel_idcode) begin
            dr_lsb = id_sr[0];
        end else if (sel_user) begin
            dr_lsb = user_sr[0];
        end
    end

    assign tap.user_dr_out = user_q;
    assign tap.user_update = user_upd_q;
`else
    logic unused_user_dr_in;

    assign unused_user_dr_in = ^tap.user_dr_in;
    assign sel_user          = 1'b0;
    assign dr_lsb            = sel_idcode ? id_sr[0] : bypass_sr;
    assign tap.user_dr_out   = '0;
    assign tap.user_update   = 1'b0;
`endif

    // tdo changes on the falling edge so the host samples it cleanly on the next rise.
    always_ff @(negedge tck or posedge trst) begin
        if (trst) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else if (state == SH_IR) begin
            tdo_q    <= ir_sr[0];
            tdo_en_q <= 1'b1;
        end else if (state == SH_DR) begin
            tdo_q    <= dr_lsb;
            tdo_en_q <= 1'b1;
        end else begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end
    end

    assign tap.tdo       = tdo_q;
    assign tap.tdo_en    = tdo_en_q;
    assign tap.tap_state = state;
    assign tap.ir_out    = ir_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// tb/tb_jtag_tap_ctrl.sv - directed-vector bench for jtag_tap_ctrl
module tb_jtag_tap_ctrl;
    localparam int          IRW = 4;
    localparam int          UW  = 16;
    localparam logic [31:0] IDC = 32'h1234_5679;
`ifdef JTAG_TAP_USER_DR_EN
    localparam int          UPD_PULSES = 1;
`else
    localparam int          UPD_PULSES = 0;
`endif

    logic tck  = 1'b0;
    logic trst = 1'b1;

    jtag_tap_ctrl_if #(.IR_WIDTH(IRW), .USER_DR_WIDTH(UW)) tap_if ();

    jtag_tap_ctrl #(
        .IR_WIDTH      (IRW),
        .IDCODE_VAL    (IDC),
        .USER_DR_WIDTH (UW)
    ) dut (
        .tck  (tck),
        .trst (trst),
        .tap  (tap_if)
    );

    always #5 tck = ~tck;

    int          n_vec   = 0;
    int          n_bad   = 0;
    int          upd_cnt = 0;
    int          en_cnt;
    int          pause_en;
    int          u0;
    logic        tdo_s;
    logic        en_s;
    logic [31:0] cap;

    always @(negedge tck) if (tap_if.user_update === 1'b1) upd_cnt++;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_user_tdo(input logic [15:0] d);
`ifdef JTAG_TAP_USER_DR_EN
        return 16'hA5C3;
`else
        return {d[14:0], 1'b0};
`endif
    endfunction

    function automatic logic [15:0] exp_user_out(input logic [15:0] d);
`ifdef JTAG_TAP_USER_DR_EN
        return d;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic tick(input logic m, input logic d);
        tap_if.tms = m;
        tap_if.tdi = d;
        @(negedge tck);
        #1;
        tdo_s = tap_if.tdo;
        en_s  = tap_if.tdo_en;
        @(posedge tck);
        #1;
    endtask

    task automatic shift_seg(input logic [31:0] val, input int lo, input int hi, input logic exit_last);
        for (int i = lo; i <= hi; i++) begin
            tick(exit_last && (i == hi), val[i]);
            cap[i] = tdo_s;
            if (en_s) en_cnt++;
        end
    endtask

    task automatic goto_sh_dr();
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic goto_sh_ir();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic finish_upd();
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic load_ir(input logic [31:0] val);
        goto_sh_ir();
        cap = '0;
        shift_seg(val, 0, IRW - 1, 1'b1);
        finish_upd();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tap_if.tms        = 1'b1;
        tap_if.tdi        = 1'b0;
        tap_if.user_dr_in = '0;
        #12;
        check_vec("rst_state", 32'(tap_if.tap_state), 32'hF);
        check_vec("rst_ir", 32'(tap_if.ir_out), 32'h1);
        check_vec("rst_tdo", 32'(tap_if.tdo), 32'h0);
        check_vec("rst_tdo_en", 32'(tap_if.tdo_en), 32'h0);
        check_vec("rst_udo", 32'(tap_if.user_dr_out), 32'h0);
        check_vec("rst_upd", 32'(tap_if.user_update), 32'h0);
        @(posedge tck);
        #1;
        trst = 1'b0;

        // IDCODE read straight out of reset
        tick(1'b0, 1'b0);
        check_vec("rti", 32'(tap_if.tap_state), 32'hC);
        goto_sh_dr();
        check_vec("sh_dr", 32'(tap_if.tap_state), 32'h2);
        cap = '0;
        en_cnt = 0;
        shift_seg(32'h0, 0, 31, 1'b1);
        check_vec("idcode_tdo", cap, IDC);
        check_vec("idcode_en", 32'(en_cnt), 32'd32);
        check_vec("idcode_ir", 32'(tap_if.ir_out), 32'h1);
        check_vec("ex1_dr", 32'(tap_if.tap_state), 32'h1);
        finish_upd();
        check_vec("upd_to_rti", 32'(tap_if.tap_state), 32'hC);

        // IR capture pattern and load of BYPASS
        load_ir(32'hF);
        check_vec("ir_capture", 32'(cap[3:0]), 32'h1);
        check_vec("ir_bypass", 32'(tap_if.ir_out), 32'hF);

        // BYPASS: tdi 1,0,1,1,0 -> tdo 0,1,0,1,1
        goto_sh_dr();
        cap = '0;
        shift_seg(32'h0D, 0, 4, 1'b1);
        check_vec("bypass_tdo", 32'(cap[4:0]), 32'h1A);
        finish_upd();

        // unassigned opcode falls back to BYPASS
        load_ir(32'h3);
        check_vec("ir_op3", 32'(tap_if.ir_out), 32'h3);
        goto_sh_dr();
        cap = '0;
        shift_seg(32'h3, 0, 1, 1'b1);
        check_vec("op3_tdo", 32'(cap[1:0]), 32'h2);
        finish_upd();

        // USER write / read, uninterrupted
        tap_if.user_dr_in = 16'hA5C3;
        load_ir(32'h8);
        check_vec("ir_user", 32'(tap_if.ir_out), 32'h8);
        goto_sh_dr();
        cap = '0;
        shift_seg(32'h3C5A, 0, 15, 1'b1);
        check_vec("user_tdo", 32'(cap[15:0]), 32'(exp_user_tdo(16'h3C5A)));
        tick(1'b1, 1'b0);
        check_vec("user_pre_udo", 32'(tap_if.user_dr_out), 32'h0);
        check_vec("user_pre_upd", 32'(tap_if.user_update), 32'h0);
        u0 = upd_cnt;
        tick(1'b0, 1'b0);
        check_vec("user_udo", 32'(tap_if.user_dr_out), 32'(exp_user_out(16'h3C5A)));
        check_vec("user_upd_hi", 32'(tap_if.user_update), 32'(UPD_PULSES));
        tick(1'b0, 1'b0);
        check_vec("user_upd_lo", 32'(tap_if.user_update), 32'h0);
        check_vec("user_upd_cnt", 32'(upd_cnt - u0), 32'(UPD_PULSES));

        // USER shift split by a three-cycle pause
        goto_sh_dr();
        cap = '0;
        en_cnt = 0;
        pause_en = 0;
        shift_seg(32'h1E69, 0, 7, 1'b1);
        tick(1'b0, 1'b0);
        check_vec("pa_dr", 32'(tap_if.tap_state), 32'h3);
        tick(1'b0, 1'b1);
        if (en_s) pause_en++;
        tick(1'b0, 1'b1);
        if (en_s) pause_en++;
        tick(1'b1, 1'b1);
        if (en_s) pause_en++;
        check_vec("pause_en", 32'(pause_en), 32'h0);
        check_vec("ex2_dr", 32'(tap_if.tap_state), 32'h0);
        tick(1'b0, 1'b0);
        shift_seg(32'h1E69, 8, 15, 1'b1);
        check_vec("split_tdo", 32'(cap[15:0]), 32'(exp_user_tdo(16'h1E69)));
        check_vec("split_en", 32'(en_cnt), 32'd16);
        finish_upd();
        check_vec("split_udo", 32'(tap_if.user_dr_out), 32'(exp_user_out(16'h1E69)));

        // trst in the middle of a USER shift
        goto_sh_dr();
        en_cnt = 0;
        shift_seg(32'hFFFF, 0, 4, 1'b0);
        check_vec("mid_sh_dr", 32'(tap_if.tap_state), 32'h2);
        check_vec("mid_en", 32'(en_s), 32'h1);
        trst = 1'b1;
        #1;
        check_vec("abort_state", 32'(tap_if.tap_state), 32'hF);
        check_vec("abort_en", 32'(tap_if.tdo_en), 32'h0);
        check_vec("abort_udo", 32'(tap_if.user_dr_out), 32'h0);
        check_vec("abort_ir", 32'(tap_if.ir_out), 32'h1);
        #2;
        trst = 1'b0;

        // five tms=1 from SH_IR, passing through UPD_IR on the way out
        tick(1'b0, 1'b0);
        load_ir(32'hF);
        check_vec("ir_reload", 32'(tap_if.ir_out), 32'hF);
        goto_sh_ir();
        check_vec("sh_ir", 32'(tap_if.tap_state), 32'hA);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1);
        check_vec("tms5_state", 32'(tap_if.tap_state), 32'hF);
        check_vec("tms5_ir", 32'(tap_if.ir_out), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/jtag_tap_ctrl.md
# jtag_tap_ctrl

- Synthesizable IEEE 1149.1 TAP controller: the target end of the JTAG interface the VIP driver stimulates.
- Samples TMS/TDI and drives TDO/TDO enable, so the VIP agent and monitor can be closed-loop checked against real RTL.
- Implements the 16-state TAP FSM, an instruction register and three data registers: IDCODE, BYPASS and an optional USER register.

## Interface
- IR_WIDTH, 4: instruction register width; minimum 4.
- IDCODE_VAL, 32'h1234_5679: IDCODE register contents; bit 0 must be 1.
- USER_DR_WIDTH, 16: USER data register width; minimum 2.

- tck  input  1  TAP clock; the block's only clock.
- trst  input  1  asynchronous reset, active-high.
- tms  input  1  test mode select, sampled on rising edge of tck.
- tdi  input  1  serial data in, sampled on rising edge of tck.
- tdo  output  1  serial data out, launched on falling edge of tck.
- tdo_en  output  1  high while tdo carries valid shift data.
- tap_state  output  4  current FSM state, encoded as listed under Operation.
- ir_out  output  IR_WIDTH  current instruction.
- user_dr_in  input  USER_DR_WIDTH  parallel value loaded into the USER shift register in CAPTURE_DR.
- user_dr_out  output  USER_DR_WIDTH  USER register value, written in UPDATE_DR.
- user_update  output  1  one-cycle pulse when user_dr_out is written.

## Operation
- State encoding:
  - TLR=F, RTI=C
  - SEL_DR=7, CAP_DR=6, SH_DR=2, EX1_DR=1, PA_DR=3, EX2_DR=0, UPD_DR=5
  - SEL_IR=4, CAP_IR=E, SH_IR=A, EX1_IR=9, PA_IR=B, EX2_IR=8, UPD_IR=D
- Transitions, written as state: tms=0 -> / tms=1 ->
  - TLR: RTI / TLR
  - RTI: RTI / SEL_DR
  - SEL_DR: CAP_DR / SEL_IR
  - SEL_IR: CAP_IR / TLR
  - CAP_x: SH_x / EX1_x
  - SH_x: SH_x / EX1_x
  - EX1_x: PA_x / UPD_x
  - PA_x: PA_x / EX2_x
  - EX2_x: SH_x / UPD_x
  - UPD_x: RTI / SEL_DR
- Opcodes:
  - IDCODE = 1
  - USER = 8
  - BYPASS = all ones
  - Any other opcode selects BYPASS.
- IR path:
  - CAP_IR loads the IR shift register with ...0001 (LSB = 1, remaining bits 0).
  - SH_IR shifts right: tdi enters the MSB, the LSB goes to tdo.
  - UPD_IR copies the shift register to ir_out.
- DR path, selected by ir_out:
  - CAP_DR loads IDCODE_VAL, 0 for BYPASS, or user_dr_in for USER.
  - SH_DR shifts right, tdi into the MSB.
  - UPD_DR with USER selected copies the shift register to user_dr_out and pulses user_update.
- Every cycle in TLR (trst or 5×tms=1) forces ir_out = IDCODE.
- Pause and exit states hold shift register contents unchanged.

## Timing
- trst asserted, asynchronously:
  - tap_state=TLR, ir_out=IDCODE, all shift registers 0.
  - user_dr_out=0, user_update=0, tdo=0, tdo_en=0.
- After trst deasserts, the first rising edge of tck is the first FSM evaluation.
- Rising edge of tck:
  - FSM state update.
  - Capture, shift and update actions, keyed on the state present before the edge.
  - user_update is registered high for exactly the cycle following the UPD_DR edge.
- Falling edge of tck:
  - tdo takes the LSB of the active shift register and tdo_en=1 when the current state is SH_DR or SH_IR.
  - Otherwise tdo=0 and tdo_en=0.
  - The VIP samples tdo on the following rising edge.
- Latency: the first bit appears on tdo half a cycle after entering SH_x, i.e. the captured LSB. BYPASS delays tdi to tdo by one tck.
- From any state, 5 consecutive tms=1 reach TLR.
- trst mid-shift aborts the shift. Partial shift data is discarded and user_dr_out is unchanged from its reset value.

## Configuration
- JTAG_TAP_USER_DR_EN defined:
  - The USER register, user_dr_in/user_dr_out/user_update behaviour and opcode 8 exist as specified.
- JTAG_TAP_USER_DR_EN undefined:
  - Opcode 8 decodes as BYPASS.
  - user_dr_out is tied to 0 and user_update to 0.
  - user_dr_in is ignored.
  - No USER shift register is synthesized.

## Test plan
- trst pulse, then tms sequence 0,1,0,0 to reach SH_DR, then 32 shifts -> tdo yields 0x1234_5679 LSB first; ir_out=1 throughout.
- Shift IR with tdi=1111 -> tdo bits 1,0,0,0; after UPD_IR, ir_out=4'hF.
- BYPASS selected, shift DR tdi=1,0,1,1,0 -> tdo=0,1,0,1,1 (one-bit delay, leading 0).
- USER: user_dr_in=16'hA5C3, load IR=8, shift DR with tdi=16'h3C5A -> tdo=16'hA5C3 LSB first; at UPD_DR, user_dr_out=16'h3C5A and user_update pulses exactly one cycle.
- USER shift split by PA_DR for 3 cycles and EX2_DR resume -> same result as the uninterrupted shift; tdo_en=0 while paused.
- trst asserted mid SH_DR of a USER write -> immediate TLR, tdo_en=0, user_dr_out=0; five tms=1 from SH_IR -> TLR, ir_out=IDCODE.
